// File: rtl/id_redirect.sv
`timescale 1ns/1ps
// id_redirect
//   Decode-side partner of fetch. Holds the IF/ID pipeline register, decodes
//   beq/bne/j/jal/jr, resolves branches in Decode using forwarded operands,
//   and drives the fetch redirect controls. Every taken redirect squashes
//   the wrong-path instruction that fetch delivers at the same edge. There is
//   no branch delay slot.
//
// Ports
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   InstrF, PCPlus4F  : fetched instruction and its PC+4
//   StallD            : holds IF/ID and masks redirects
//   RD1D, RD2D        : register-file read data (rs, rt) for InstrD
//   ALUOutM           : Memory-stage result used for forwarding
//   ForwardAD/BD      : select ALUOutM for operand A / B
//   InstrD, PCPlus4D  : IF/ID registers
//   ValidD            : InstrD holds a real instruction (not a bubble)
//   PCSrcD            : 00 = PC+4, 01 = branch target, 10 = jump target
//   PCBranchD         : branch target, driven every cycle
//   jumpdst           : jump target (register A for jr)
//   RedirectCount     : saturating count of taken redirects
module id_redirect (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrF,
  input  logic [31:0] PCPlus4F,
  input  logic        StallD,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  input  logic [31:0] ALUOutM,
  input  logic        ForwardAD,
  input  logic        ForwardBD,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [1:0]  PCSrcD,
  output logic [31:0] PCBranchD,
  output logic [31:0] jumpdst,
  output logic [31:0] RedirectCount
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FN_JR    = 6'b001000;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        is_beq;
  logic        is_bne;
  logic        is_jr;
  logic        is_jump;
  logic        branch_taken;
  logic [31:0] imm_sext_sh;

  assign op    = InstrD[31:26];
  assign funct = InstrD[5:0];

  assign opa = ForwardAD ? ALUOutM : RD1D;
  assign opb = ForwardBD ? ALUOutM : RD2D;

  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = (op == OP_BNE);
  assign is_jr   = (op == OP_RTYPE) && (funct == FN_JR);
  assign is_jump = (op == OP_J) || (op == OP_JAL) || is_jr;

  assign branch_taken = (is_beq && (opa == opb)) || (is_bne && (opa != opb));

  assign imm_sext_sh = {{14{InstrD[15]}}, InstrD[15:0], 2'b00};
  assign PCBranchD   = PCPlus4D + imm_sext_sh;
  assign jumpdst     = is_jr ? opa : {PCPlus4D[31:28], InstrD[25:0], 2'b00};

  always_comb begin
    PCSrcD = 2'b00;
    if (ValidD && !StallD && !reset) begin
      if (branch_taken)
        PCSrcD = 2'b01;
      else if (is_jump)
        PCSrcD = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      InstrD   <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCPlus4D <= PCPlus4D;
      ValidD   <= ValidD;
    end else if (PCSrcD != 2'b00) begin
      // Squash the wrong-path fetch that arrives with the redirect.
      InstrD   <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else begin
      InstrD   <= InstrF;
      PCPlus4D <= PCPlus4F;
      ValidD   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      RedirectCount <= '0;
    else if ((PCSrcD != 2'b00) && (RedirectCount != '1))
      RedirectCount <= RedirectCount + 32'd1;
  end

endmodule

// File: doc/id_redirect.md
# id_redirect

Decode-side partner of the fetch stage. Holds the IF/ID pipeline register, decodes control-flow instructions, resolves branches in Decode with forwarded operands, and drives the fetch redirect interface `PCSrcD`, `PCBranchD` and `jumpdst` back to fetch. It squashes the wrong-path instruction after every taken redirect. There is no branch delay slot.

## Interface
Parameters: none; all datapaths are 32 bits.

- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — synchronous, active-high.
- `InstrF`  in  32  — fetched instruction.
- `PCPlus4F`  in  32  — PC+4 of the fetched instruction.
- `StallD`  in  1  — from the hazard unit; holds IF/ID and suppresses redirects.
- `RD1D`, `RD2D`  in  32  — register-file read data for rs and rt of `InstrD`.
- `ALUOutM`  in  32  — Memory-stage ALU result, used for forwarding.
- `ForwardAD`, `ForwardBD`  in  1  — select `ALUOutM` instead of `RD1D` / `RD2D`.
- `InstrD`  out  32  — IF/ID instruction register.
- `PCPlus4D`  out  32  — IF/ID PC+4 register.
- `ValidD`  out  1  — `InstrD` is a real instruction, not a bubble.
- `PCSrcD`  out  2  — fetch mux select: 00 = PC+4, 01 = branch target, 10 = jump target. 11 is never driven.
- `PCBranchD`  out  32  — branch target.
- `jumpdst`  out  32  — jump target.
- `RedirectCount`  out  32  — count of taken redirects.

## Operation
Operand selection:
- `A` = `ForwardAD` ? `ALUOutM` : `RD1D`.
- `B` = `ForwardBD` ? `ALUOutM` : `RD2D`.

Decode, on `InstrD[31:26]` (op) and `InstrD[5:0]` (funct):
- beq: op 000100; taken when A == B.
- bne: op 000101; taken when A != B.
- j: op 000010.
- jal: op 000011. The link write is owned by downstream stages, not this block.
- jr: op 000000 with funct 001000.

Targets:
- `PCBranchD` = `PCPlus4D` + (sign-extended `InstrD[15:0]` << 2), modulo 2^32. Driven every cycle regardless of opcode.
- `jumpdst` for j/jal = {`PCPlus4D[31:28]`, `InstrD[25:0]`, 2'b00}.
- `jumpdst` for jr = A.
- `jumpdst` for all other opcodes = {`PCPlus4D[31:28]`, `InstrD[25:0]`, 2'b00}.

PCSrcD, combinational:
- Forced to 00 when `ValidD` = 0, `StallD` = 1, or `reset` = 1.
- Otherwise 01 for a taken beq/bne.
- Otherwise 10 for j, jal or jr.
- Otherwise 00.

IF/ID register, updated on each rising edge in this priority order:
1. `reset`: `InstrD` = 0, `PCPlus4D` = 0, `ValidD` = 0.
2. `StallD`: hold all three registers.
3. `PCSrcD` != 00 (redirect): flush. `InstrD` = 0 (nop), `PCPlus4D` = 0, `ValidD` = 0. The wrong-path `InstrF` is discarded.
4. Otherwise: load `InstrF` and `PCPlus4F`, and set `ValidD` = 1.

RedirectCount:
- Increments by 1 on each edge where `PCSrcD` != 00 and `reset` = 0.
- Saturates at 32'hFFFFFFFF; no wrap.
- Reset value 0.

## Timing
- Reset values: `InstrD` = 0, `PCPlus4D` = 0, `ValidD` = 0, `RedirectCount` = 0, `PCSrcD` = 00.
- `PCBranchD` and `jumpdst` are combinational from the reset state: 32'h00000000 after reset.
- Fetch-to-decode latency: 1 cycle. `InstrF` sampled at edge N appears on `InstrD` after edge N.
- Redirect is combinational in the same cycle the instruction sits in Decode. Fetch loads the target at the next edge, and IF/ID takes a bubble at that same edge: exactly one squashed slot per taken redirect.
- Back-to-back redirects are impossible: the bubble following a redirect has `ValidD` = 0.
- Stall during redirect: `StallD` = 1 masks the redirect. Fetch sees 00 and, under the shared stall, holds its PC. The redirect fires on the first unstalled cycle using the then-current forwarded operands.
- Reset asserted mid-stall or mid-redirect: reset wins. No count increment occurs on that edge.
- Forwarding selects are consumed combinationally in the same cycle. The hazard unit guarantees operand readiness whenever `StallD` = 0.

## Test plan
- **Reset:** hold `reset` for 2 cycles with `InstrF` = 32'h1000FFFF → `InstrD` = 0, `ValidD` = 0, `PCSrcD` = 00, `RedirectCount` = 0.
- **Taken beq, backward offset:** `InstrF` = 32'h1109FFFE (beq, imm = -2), `PCPlus4F` = 32'h00000104, `RD1D` = `RD2D` = 5, then one edge → `PCSrcD` = 01, `PCBranchD` = 32'h000000FC. The next edge flushes: `ValidD` = 0, `InstrD` = 0, `RedirectCount` = 1.
- **Not-taken bne:** same operands, `InstrF` = 32'h15090003 → `PCSrcD` = 00, `PCBranchD` = 32'h00000110. The next instruction loads normally with `ValidD` = 1.
- **jal and jr with forwarding:**
  - jal: `InstrF` = 32'h0C000040, `PCPlus4D` = 32'h40000008 → `PCSrcD` = 10, `jumpdst` = 32'h40000100.
  - jr: `InstrF` = 32'h03E00008, `ForwardAD` = 1, `ALUOutM` = 32'h00400020 → `jumpdst` = 32'h00400020.
- **Stall over a taken branch:** taken beq in Decode with `StallD` = 1 for 3 cycles → `PCSrcD` = 00 and IF/ID held throughout. When `StallD` is released → `PCSrcD` = 01, followed by exactly one flush and `RedirectCount` +1.
- **Counter saturation:** force 32'hFFFFFFFE counts, then drive 3 further taken jumps → `RedirectCount` = 32'hFFFFFFFF and stays there.
